ptt144_ctrl: RTL and testbench

- Conditions the operator's raw 144 MHz PTT key and drives the active-low `ptt` input of the 144 MHz TX/RX sequencer. It is the initiating end of that interface.
- Debounces the key and enforces a transmit time-out timer (TOT) with warning, fault and lockout.
- Reports when the PA is actually keyed, using the sequencer's `pa144` output as feedback.
- Sits between the front-panel/footswitch input and the sequencer in the station-control fabric.

---
 rtl/seq_pkg.sv | 26 ++
 rtl/ptt144_ctrl_if.sv | 24 ++
 rtl/key_debounce.sv | 49 ++++
 rtl/ptt144_ctrl.sv | 110 +++++++++++
 tb/tb_ptt144_ctrl.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/seq_pkg.sv
// Shared definitions for the 144 MHz station-control blocks.
// Holds the one-hot PTT controller state encodings, the default 50 MHz timing
// constants shared with the TX/RX sequencer, and a saturating counter helper.
package seq_pkg;

  // One-hot controller states
  typedef enum logic [3:0] {
    PTT_IDLE    = 4'b0001,
    PTT_TX      = 4'b0010,
    PTT_TIMEOUT = 4'b0100,
    PTT_LOCKOUT = 4'b1000
  } ptt_state_e;

  // Default timing at a 50 MHz system clock
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 500000;    // 10 ms
  localparam int unsigned DEF_TICK_CYCLES     = 50000000;  // 1 s
  localparam int unsigned DEF_TOT_SECONDS     = 180;
  localparam int unsigned DEF_WARN_SECONDS    = 15;
  localparam int unsigned DEF_LOCKOUT_SECONDS = 10;

  // 8-bit increment that sticks at 255
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hff) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/ptt144_ctrl_if.sv
// Signal bundle of the 144 MHz PTT controller.
// Carries the operator key and TOT enable in, the sequencer PA feedback in,
// and the sequencer PTT plus status flags out.
//   master : controller side (ptt144_ctrl)
//   slave  : environment side (key input, sequencer, status consumers)
interface ptt144_ctrl_if;
  logic ptt_key_n;  // raw operator key, 0 = transmit request
  logic tot_en;     // 1 = time-out timer enforced
  logic pa_on;      // sequencer pa144 feedback, 1 = PA enabled
  logic ptt;        // to sequencer, 0 = transmit
  logic tx_active;  // TX state with PA confirmed on
  logic tot_warn;   // pre-timeout warning
  logic tot_fault;  // time-out occurred, held through lockout

  modport master (
    input  ptt_key_n, tot_en, pa_on,
    output ptt, tx_active, tot_warn, tot_fault
  );

  modport slave (
    output ptt_key_n, tot_en, pa_on,
    input  ptt, tx_active, tot_warn, tot_fault
  );
endinterface

// File: rtl/key_debounce.sv
// Key synchronizer and debouncer.
// Two-flop synchronizer followed by a stability counter: the debounced level
// follows the synchronized key only after DEBOUNCE_CYCLES consecutive samples
// that differ from the current debounced level.
// Ports:
//   clk    in  system clock
//   reset  in  asynchronous active-low reset
//   key_n  in  raw asynchronous key, active low
//   key_db out debounced key level (1 after reset)
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic key_db
);

  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  logic            sync1_q, sync2_q;
  logic [CntW-1:0] cnt_q;
  logic            key_db_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      cnt_q    <= '0;
      key_db_q <= 1'b1;
    end else begin
      sync1_q <= key_n;
      sync2_q <= sync1_q;
      if (sync2_q == key_db_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CntMax) begin
        // This sample is the DEBOUNCE_CYCLES-th differing one: accept it
        key_db_q <= sync2_q;
        cnt_q    <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign key_db = key_db_q;

endmodule

// File: rtl/ptt144_ctrl.sv
// 144 MHz PTT controller.
// Debounces the operator key, drives the sequencer's active-low PTT, runs a
// transmit time-out timer with warning, fault and post-timeout lockout, and
// reports when the PA is confirmed keyed.
// Ports:
//   clk    in  system clock
//   reset  in  asynchronous active-low reset; forces ptt = 1 immediately
//   bus    master modport: ptt_key_n, tot_en, pa_on in;
//          ptt, tx_active, tot_warn, tot_fault out (all registered)
module ptt144_ctrl
  import seq_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned TICK_CYCLES     = DEF_TICK_CYCLES,
  parameter int unsigned TOT_SECONDS     = DEF_TOT_SECONDS,
  parameter int unsigned WARN_SECONDS    = DEF_WARN_SECONDS,
  parameter int unsigned LOCKOUT_SECONDS = DEF_LOCKOUT_SECONDS
) (
  input  logic              clk,
  input  logic              reset,
  ptt144_ctrl_if.master     bus
);

  localparam int unsigned PreW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [PreW-1:0] PreMax = PreW'(TICK_CYCLES - 1);
  localparam logic [7:0] TotLimit  = 8'(TOT_SECONDS);
  localparam logic [7:0] WarnStart = 8'(TOT_SECONDS - WARN_SECONDS);
  localparam logic [7:0] LockLimit = 8'(LOCKOUT_SECONDS);

  logic key_db;

  key_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_key_debounce (
    .clk    (clk),
    .reset  (reset),
    .key_n  (bus.ptt_key_n),
    .key_db (key_db)
  );

  ptt_state_e      state_q, state_d;
  logic [PreW-1:0] pre_q, pre_d;
  logic [7:0]      sec_q, sec_d, sec_inc;
  logic            tick;
  logic            ptt_d, tx_active_d, tot_warn_d, tot_fault_d;

  always_comb begin
    tick    = (pre_q == PreMax);
    // Seconds value including a tick landing this cycle, so limits act on
    // the same edge the second completes.
    sec_inc = tick ? sat_inc8(sec_q) : sec_q;

    state_d = state_q;
    unique case (state_q)
      PTT_IDLE: begin
        if (!key_db) state_d = PTT_TX;
      end
      PTT_TX: begin
        if (key_db) begin
          state_d = PTT_IDLE;
        end else if (bus.tot_en && (sec_inc >= TotLimit)) begin
          state_d = PTT_TIMEOUT;
        end
      end
      PTT_TIMEOUT: begin
        if (key_db) state_d = PTT_LOCKOUT;
      end
      PTT_LOCKOUT: begin
        // A key still held at lockout end keeps us here until released
        if ((sec_inc >= LockLimit) && key_db) state_d = PTT_IDLE;
      end
      default: state_d = PTT_IDLE;
    endcase

    // Timebase restarts on every state entry
    if (state_d != state_q) begin
      pre_d = '0;
      sec_d = '0;
    end else begin
      pre_d = tick ? '0 : pre_q + 1'b1;
      sec_d = sec_inc;
    end

    ptt_d       = (state_d != PTT_TX);
    tot_warn_d  = (state_d == PTT_TX) && bus.tot_en && (sec_d >= WarnStart);
    tot_fault_d = (state_d == PTT_TIMEOUT) || (state_d == PTT_LOCKOUT);
    tx_active_d = (state_q == PTT_TX) && bus.pa_on;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= PTT_IDLE;
      pre_q         <= '0;
      sec_q         <= '0;
      bus.ptt       <= 1'b1;
      bus.tx_active <= 1'b0;
      bus.tot_warn  <= 1'b0;
      bus.tot_fault <= 1'b0;
    end else begin
      state_q       <= state_d;
      pre_q         <= pre_d;
      sec_q         <= sec_d;
      bus.ptt       <= ptt_d;
      bus.tx_active <= tx_active_d;
      bus.tot_warn  <= tot_warn_d;
      bus.tot_fault <= tot_fault_d;
    end
  end

endmodule

// File: tb/tb_ptt144_ctrl.sv
// Directed self-checking bench for ptt144_ctrl with short timing parameters:
// debounce 4, tick 10 cycles, TOT 5 s, warn 2 s, lockout 3 s.
// Inputs change just after a falling clock edge; outputs are sampled there too.
module tb_ptt144_ctrl;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  ptt144_ctrl_if bus ();

  ptt144_ctrl #(
    .DEBOUNCE_CYCLES (4),
    .TICK_CYCLES     (10),
    .TOT_SECONDS     (5),
    .WARN_SECONDS    (2),
    .LOCKOUT_SECONDS (3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b0;
    bus.ptt_key_n = 1'b0;
    bus.tot_en = 1'b1;
    bus.pa_on = 1'b0;

    // 1. Reset held with key pressed
    wait_n(3);
    check("rst_ptt", bus.ptt, 1'b1);
    check("rst_tx_active", bus.tx_active, 1'b0);
    check("rst_warn", bus.tot_warn, 1'b0);
    check("rst_fault", bus.tot_fault, 1'b0);
    reset = 1'b1;
    wait_n(6);
    check("rst_lat_6", bus.ptt, 1'b1);
    wait_n(1);
    check("rst_lat_7", bus.ptt, 1'b0);

    // Release back to idle
    bus.ptt_key_n = 1'b1;
    wait_n(6);
    check("rel_lat_6", bus.ptt, 1'b0);
    wait_n(1);
    check("rel_lat_7", bus.ptt, 1'b1);

    // 2. Bounce rejection: 3-cycle lows with 2-cycle gaps
    for (int i = 0; i < 4; i++) begin
      bus.ptt_key_n = 1'b0;
      for (int j = 0; j < 3; j++) begin
        wait_n(1);
        check("bounce_low", bus.ptt, 1'b1);
      end
      bus.ptt_key_n = 1'b1;
      for (int j = 0; j < 2; j++) begin
        wait_n(1);
        check("bounce_gap", bus.ptt, 1'b1);
      end
    end
    wait_n(10);
    check("bounce_settle", bus.ptt, 1'b1);

    // Clean press
    bus.ptt_key_n = 1'b0;
    wait_n(6);
    check("press_lat_6", bus.ptt, 1'b1);
    wait_n(1);
    check("press_lat_7", bus.ptt, 1'b0);

    // 3. Time-out: warn at +30, timeout at +50 after TX entry
    wait_n(29);
    check("warn_pre", bus.tot_warn, 1'b0);
    wait_n(1);
    check("warn_rise", bus.tot_warn, 1'b1);
    check("warn_ptt", bus.ptt, 1'b0);
    wait_n(19);
    check("tot_pre_ptt", bus.ptt, 1'b0);
    check("tot_pre_warn", bus.tot_warn, 1'b1);
    wait_n(1);
    check("tot_ptt", bus.ptt, 1'b1);
    check("tot_fault", bus.tot_fault, 1'b1);
    check("tot_warn_clr", bus.tot_warn, 1'b0);
    wait_n(20);
    check("tot_hold_ptt", bus.ptt, 1'b1);
    check("tot_hold_fault", bus.tot_fault, 1'b1);

    // 4. Lockout: release, re-press early, hold past lockout end
    bus.ptt_key_n = 1'b1;
    wait_n(7);
    wait_n(5);
    bus.ptt_key_n = 1'b0;
    wait_n(15);
    check("lock_repress_ptt", bus.ptt, 1'b1);
    wait_n(20);
    check("lock_held_ptt", bus.ptt, 1'b1);
    check("lock_held_fault", bus.tot_fault, 1'b1);
    bus.ptt_key_n = 1'b1;
    wait_n(6);
    check("lock_rel_6_fault", bus.tot_fault, 1'b1);
    wait_n(1);
    check("lock_rel_7_fault", bus.tot_fault, 1'b0);
    check("lock_rel_7_ptt", bus.ptt, 1'b1);
    bus.ptt_key_n = 1'b0;
    wait_n(6);
    check("repress_6", bus.ptt, 1'b1);
    wait_n(1);
    check("repress_7", bus.ptt, 1'b0);

    // 5. TOT disabled while transmitting for 100 cycles
    bus.tot_en = 1'b0;
    for (int i = 0; i < 100; i++) begin
      wait_n(1);
      check("toten0_ptt", bus.ptt, 1'b0);
      check("toten0_warn", bus.tot_warn, 1'b0);
      check("toten0_fault", bus.tot_fault, 1'b0);
    end
    bus.tot_en = 1'b1;
    wait_n(1);
    check("toten1_ptt", bus.ptt, 1'b1);
    check("toten1_fault", bus.tot_fault, 1'b1);
    check("toten1_warn", bus.tot_warn, 1'b0);

    // Release with no re-press: lockout ends 30 cycles after entry
    bus.ptt_key_n = 1'b1;
    wait_n(36);
    check("lock_end_pre", bus.tot_fault, 1'b1);
    wait_n(1);
    check("lock_end", bus.tot_fault, 1'b0);
    check("lock_end_ptt", bus.ptt, 1'b1);

    // 6. PA feedback
    bus.pa_on = 1'b1;
    wait_n(3);
    check("pa_idle_txa", bus.tx_active, 1'b0);
    bus.pa_on = 1'b0;
    bus.ptt_key_n = 1'b0;
    wait_n(7);
    check("pa_tx_ptt", bus.ptt, 1'b0);
    check("pa_off_txa", bus.tx_active, 1'b0);
    bus.pa_on = 1'b1;
    wait_n(1);
    check("pa_on_txa", bus.tx_active, 1'b1);

    // Asynchronous reset between clock edges
    #2;
    reset = 1'b0;
    #1;
    check("async_rst_ptt", bus.ptt, 1'b1);
    check("async_rst_txa", bus.tx_active, 1'b0);
    wait_n(2);
    reset = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
